// File: rtl/cp0_exc_sequencer.sv
// Exception/ERET sequencer between decode and the CP0 register file.
// Masks and prioritises traps/IRQs, strobes CP0 and redirects fetch.
module cp0_exc_sequencer #(
    parameter int          N_IRQ      = 2,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004,
    parameter logic [4:0]  C_SYSCALL  = 5'd8,
    parameter logic [4:0]  C_BREAK    = 5'd9,
    parameter logic [4:0]  C_TEQ      = 5'd13,
    parameter logic [4:0]  C_INT      = 5'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             syscall_req,
    input  logic             break_req,
    input  logic             teq_req,
    input  logic             eret_req,
    input  logic [N_IRQ-1:0] irq,
    input  logic [31:0]      instr_pc,
    input  logic [31:0]      status,
    input  logic [31:0]      epc,
    output logic             exception,
    output logic             eret,
    output logic [4:0]       cause,
    output logic [31:0]      exc_pc,
    output logic             stall,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXC,
        S_RET,
        S_REDIR
    } state_t;

    state_t             state_q, state_d;
    logic [N_IRQ-1:0]   irq_prev_q, irq_prev_d;
    logic [N_IRQ-1:0]   irq_pend_q, irq_pend_d;
    logic               exception_q, exception_d;
    logic               eret_q, eret_d;
    logic [4:0]         cause_q, cause_d;
    logic [31:0]        exc_pc_q, exc_pc_d;
    logic               redir_valid_q, redir_valid_d;
    logic [31:0]        redir_pc_q, redir_pc_d;

    logic               en;
    logic               acc_sys;
    logic               acc_brk;
    logic               acc_teq;
    logic               acc_sync;
    logic [N_IRQ-1:0]   irq_acc;
    logic [N_IRQ-1:0]   irq_sel;
    logic               irq_any;
    logic               is_idle;
    logic               take_trap;
    logic               take_eret;
    logic [N_IRQ-1:0]   irq_clr;

    // Event qualification; only meaningful while idle
    always_comb begin
        en       = status[0];
        acc_sys  = en & status[1] & syscall_req;
        acc_brk  = en & status[2] & break_req;
        acc_teq  = en & status[3] & teq_req;
        acc_sync = acc_sys | acc_brk | acc_teq;
        irq_acc  = irq_pend_q & {N_IRQ{en}};
        irq_sel  = '0;
        irq_any  = 1'b0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (irq_acc[k] && !irq_any) begin
                irq_sel[k] = 1'b1;
                irq_any    = 1'b1;
            end
        end
        is_idle   = (state_q == S_IDLE);
        take_trap = is_idle & (acc_sync | irq_any);
        take_eret = is_idle & eret_req & ~take_trap;
        irq_clr   = (take_trap && !acc_sync) ? irq_sel : '0;
    end

    // A fresh edge on the same cycle its old pend is consumed stays pending
    always_comb begin
        irq_prev_d = irq;
        irq_pend_d = (irq_pend_q & ~irq_clr) | (irq & ~irq_prev_q);
    end

    always_comb begin
        state_d       = state_q;
        exception_d   = 1'b0;
        eret_d        = 1'b0;
        cause_d       = cause_q;
        exc_pc_d      = exc_pc_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        stall         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (take_trap) begin
                    state_d     = S_EXC;
                    exception_d = 1'b1;
                    exc_pc_d    = instr_pc;
                    redir_pc_d  = EXC_VECTOR;
                    stall       = 1'b1;
                    if (acc_sys)
                        cause_d = C_SYSCALL;
                    else if (acc_brk)
                        cause_d = C_BREAK;
                    else if (acc_teq)
                        cause_d = C_TEQ;
                    else
                        cause_d = C_INT;
                end else if (take_eret) begin
                    state_d    = S_RET;
                    eret_d     = 1'b1;
                    redir_pc_d = epc;
                end
            end
            S_EXC, S_RET: begin
                state_d       = S_REDIR;
                redir_valid_d = 1'b1;
                stall         = 1'b1;
            end
            S_REDIR: begin
                stall = 1'b1;
                if (redir_ready)
                    state_d = S_IDLE;
                else
                    redir_valid_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            irq_prev_q    <= '0;
            irq_pend_q    <= '0;
            exception_q   <= 1'b0;
            eret_q        <= 1'b0;
            cause_q       <= 5'd0;
            exc_pc_q      <= 32'd0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            irq_prev_q    <= irq_prev_d;
            irq_pend_q    <= irq_pend_d;
            exception_q   <= exception_d;
            eret_q        <= eret_d;
            cause_q       <= cause_d;
            exc_pc_q      <= exc_pc_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign exception   = exception_q;
    assign eret        = eret_q;
    assign cause       = cause_q;
    assign exc_pc      = exc_pc_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Directed bench for cp0_exc_sequencer.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_cp0_exc_sequencer;

    logic        clk;
    logic        rst;
    logic        syscall_req;
    logic        break_req;
    logic        teq_req;
    logic        eret_req;
    logic [1:0]  irq;
    logic [31:0] instr_pc;
    logic [31:0] status;
    logic [31:0] epc;
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] exc_pc;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;

    int checks = 0;
    int errors = 0;

    cp0_exc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .syscall_req (syscall_req),
        .break_req   (break_req),
        .teq_req     (teq_req),
        .eret_req    (eret_req),
        .irq         (irq),
        .instr_pc    (instr_pc),
        .status      (status),
        .epc         (epc),
        .exception   (exception),
        .eret        (eret),
        .cause       (cause),
        .exc_pc      (exc_pc),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_ready (redir_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        syscall_req = 1'b0;
        break_req   = 1'b0;
        teq_req     = 1'b0;
        eret_req    = 1'b0;
        irq         = 2'b00;
        instr_pc    = 32'h0;
        status      = 32'h0;
        epc         = 32'h0;
        redir_ready = 1'b1;
        tick();
        tick();
        chk("rst_exception", exception, 0);
        chk("rst_eret", eret, 0);
        chk("rst_cause", cause, 0);
        chk("rst_exc_pc", exc_pc, 0);
        chk("rst_stall", stall, 0);
        chk("rst_redir_valid", redir_valid, 0);
        chk("rst_redir_pc", redir_pc, 0);
        rst = 1'b0;
        tick();

        // 1: basic syscall
        status      = 32'h1F;
        instr_pc    = 32'h00400020;
        syscall_req = 1'b1;
        #1 chk("t1_stall_comb", stall, 1);
        tick();
        syscall_req = 1'b0;
        chk("t1_exception", exception, 1);
        chk("t1_cause", cause, 8);
        chk("t1_exc_pc", exc_pc, 32'h00400020);
        chk("t1_redir_valid_early", redir_valid, 0);
        chk("t1_stall_exc", stall, 1);
        tick();
        chk("t1_exception_off", exception, 0);
        chk("t1_redir_valid", redir_valid, 1);
        chk("t1_redir_pc", redir_pc, 32'h00400004);
        tick();
        chk("t1_idle_valid", redir_valid, 0);
        chk("t1_idle_stall", stall, 0);

        // masked syscall (status[1]=0) is dropped
        status      = 32'h1D;
        syscall_req = 1'b1;
        #1 chk("mask_sys_stall", stall, 0);
        tick();
        syscall_req = 1'b0;
        chk("mask_sys_exc", exception, 0);

        // 2: syscall+break+irq0 edge together
        status      = 32'h1F;
        instr_pc    = 32'h00400028;
        syscall_req = 1'b1;
        break_req   = 1'b1;
        irq         = 2'b01;
        tick();
        syscall_req = 1'b0;
        break_req   = 1'b0;
        irq         = 2'b00;
        status      = 32'h3E0;
        chk("t2_exception", exception, 1);
        chk("t2_cause", cause, 8);
        tick();
        tick();
        chk("t2_idle_masked_stall", stall, 0);
        epc      = 32'h00400024;
        eret_req = 1'b1;
        tick();
        eret_req = 1'b0;
        status   = 32'h1F;
        chk("t2_eret", eret, 1);
        chk("t2_eret_noexc", exception, 0);
        tick();
        chk("t2_redir_pc", redir_pc, 32'h00400024);
        instr_pc = 32'h00400024;
        tick();
        chk("t2_pend_stall", stall, 1);
        tick();
        chk("t2_irq_exception", exception, 1);
        chk("t2_irq_cause", cause, 0);
        chk("t2_irq_exc_pc", exc_pc, 32'h00400024);
        tick();
        tick();
        chk("t2_pend_cleared", stall, 0);
        tick();
        chk("t2_no_repeat", exception, 0);

        // 3: masked teq dropped, irq1 held pending
        status  = 32'h3E0;
        teq_req = 1'b1;
        #1 chk("t3_teq_stall", stall, 0);
        tick();
        teq_req = 1'b0;
        chk("t3_teq_exc", exception, 0);
        irq = 2'b10;
        tick();
        irq = 2'b00;
        tick();
        chk("t3_held_exc", exception, 0);
        chk("t3_held_stall", stall, 0);
        status = 32'h1F;
        #1 chk("t3_unmask_stall", stall, 1);
        tick();
        chk("t3_exception", exception, 1);
        chk("t3_cause", cause, 0);
        tick();
        tick();
        chk("t3_back_idle", stall, 0);

        // 4: eret with delayed ready
        epc         = 32'h00400108;
        redir_ready = 1'b0;
        eret_req    = 1'b1;
        tick();
        eret_req = 1'b0;
        chk("t4_eret", eret, 1);
        chk("t4_noexc", exception, 0);
        tick();
        chk("t4_eret_off", eret, 0);
        chk("t4_valid0", redir_valid, 1);
        chk("t4_redir_pc", redir_pc, 32'h00400108);
        chk("t4_stall0", stall, 1);
        tick();
        chk("t4_valid1", redir_valid, 1);
        chk("t4_stall1", stall, 1);
        tick();
        chk("t4_valid2", redir_valid, 1);
        chk("t4_pc2", redir_pc, 32'h00400108);
        redir_ready = 1'b1;
        tick();
        chk("t4_idle_valid", redir_valid, 0);
        chk("t4_idle_stall", stall, 0);

        // 5: break beats eret
        instr_pc  = 32'h00400050;
        break_req = 1'b1;
        eret_req  = 1'b1;
        tick();
        break_req = 1'b0;
        eret_req  = 1'b0;
        chk("t5_exception", exception, 1);
        chk("t5_cause", cause, 9);
        chk("t5_no_eret", eret, 0);
        tick();
        chk("t5_no_eret2", eret, 0);
        tick();

        // 6: reset during REDIR
        redir_ready = 1'b0;
        instr_pc    = 32'h00400060;
        syscall_req = 1'b1;
        tick();
        syscall_req = 1'b0;
        tick();
        chk("t6_in_redir", redir_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", redir_valid, 0);
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_pc", redir_pc, 0);
        chk("t6_rst_cause", cause, 0);
        chk("t6_rst_exc_pc", exc_pc, 0);
        tick();
        rst         = 1'b0;
        redir_ready = 1'b1;
        tick();
        instr_pc    = 32'h00400070;
        syscall_req = 1'b1;
        tick();
        syscall_req = 1'b0;
        chk("t6_exception", exception, 1);
        chk("t6_cause", cause, 8);
        chk("t6_exc_pc", exc_pc, 32'h00400070);
        tick();
        chk("t6_redir_pc", redir_pc, 32'h00400004);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
